// File: rtl/g2b_rr_sched.sv
// g2b_rr_sched: one Gray-to-binary converter shared by NREQ requesters.
//
// A round-robin arbiter picks one pending requester while idle. The accepted
// Gray word and the requester index are latched, converted in the next cycle,
// and presented as a registered, id-tagged result until the consumer takes it.
// Every accepted conversion takes three states: IDLE -> CONV -> OUT.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   req_valid   per-requester "word pending"
//   req_gray    requester i word at [i*WIDTH +: WIDTH]
//   req_ready   one-hot grant/accept (only in IDLE, never during reset)
//   out_valid   result available (OUT state only)
//   out_ready   consumer accepts the result
//   out_binary  converted binary word
//   out_id      index of the requester that produced out_binary
//   busy        high whenever the FSM is not IDLE
//   conv_count  number of results accepted by the consumer (wrapping)
module g2b_rr_sched #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = 2,
    parameter int unsigned CNTW  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_gray,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_binary,
    output logic [IDW-1:0]        out_id,
    output logic                  busy,
    output logic [CNTW-1:0]       conv_count
);

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StOut
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic [WIDTH-1:0] out_binary_q, out_binary_d;
    logic [IDW-1:0]   out_id_q, out_id_d;
    logic             out_valid_q, out_valid_d;
    logic [CNTW-1:0]  conv_count_q, conv_count_d;

    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [NREQ-1:0]  grant_oh;
    logic [IDW:0]     cand_sum;
    logic [IDW:0]     cand;
    logic [WIDTH-1:0] conv_bin;

    // Round-robin search: rr_ptr, rr_ptr+1, ... modulo NREQ. The sum is one bit
    // wider so the wrap can be done with a single conditional subtract.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            cand     = cand_sum - ((cand_sum >= (IDW+1)'(NREQ)) ? (IDW+1)'(NREQ) : '0);
            if (!grant_found && req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    // Grant is only offered while idle and out of reset, so it is the accept.
    always_comb begin
        grant_oh = '0;
        if (state_q == StIdle && !rst && grant_found) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // Binary bit k is the XOR of all Gray bits at or above k.
    always_comb begin
        conv_bin = '0;
        for (int k = 0; k < int'(WIDTH); k++) begin
            conv_bin[k] = ^(gray_q >> k);
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        gray_d       = gray_q;
        out_binary_d = out_binary_q;
        out_id_d     = out_id_q;
        out_valid_d  = out_valid_q;
        conv_count_d = conv_count_q;
        case (state_q)
            StIdle: begin
                if (grant_found) begin
                    gray_d  = req_gray[grant_idx*WIDTH +: WIDTH];
                    id_d    = grant_idx;
                    state_d = StConv;
                end
            end
            StConv: begin
                out_binary_d = conv_bin;
                out_id_d     = id_q;
                out_valid_d  = 1'b1;
                state_d      = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d  = 1'b0;
                    conv_count_d = conv_count_q + CNTW'(1);
                    // Next search starts just after the requester just served.
                    rr_ptr_d     = (out_id_q == IDW'(NREQ - 1)) ? '0 : out_id_q + IDW'(1);
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            gray_q       <= '0;
            out_binary_q <= '0;
            out_id_q     <= '0;
            out_valid_q  <= 1'b0;
            conv_count_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            gray_q       <= gray_d;
            out_binary_q <= out_binary_d;
            out_id_q     <= out_id_d;
            out_valid_q  <= out_valid_d;
            conv_count_q <= conv_count_d;
        end
    end

    assign req_ready  = grant_oh;
    assign out_valid  = out_valid_q;
    assign out_binary = out_binary_q;
    assign out_id     = out_id_q;
    assign busy       = (state_q != StIdle);
    assign conv_count = conv_count_q;

endmodule

// File: tb/tb_g2b_rr_sched.sv
// Bench for g2b_rr_sched: per-requester source queues drive the request side,
// a transaction-level model predicts grants/timing and pushes expected results,
// and a separate monitor compares every presented result against the queue.
module tb_g2b_rr_sched;

    localparam int WIDTH = 5;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int CNTW  = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_gray;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_binary;
    logic [IDW-1:0]        out_id;
    logic                  busy;
    logic [CNTW-1:0]       conv_count;

    g2b_rr_sched #(
        .WIDTH(WIDTH),
        .NREQ (NREQ),
        .IDW  (IDW),
        .CNTW (CNTW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_gray  (req_gray),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_binary(out_binary),
        .out_id    (out_id),
        .busy      (busy),
        .conv_count(conv_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference conversion: fold successively shifted copies of the Gray word.
    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        b = g;
        s = g >> 1;
        while (s != 0) begin
            b = b ^ s;
            s = s >> 1;
        end
        return b;
    endfunction

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] bin;
    } exp_t;

    exp_t sb[$];
    int   acc_ids[$];
    int   exp_ids[$];

    // Transaction-level model: one conversion in flight, age counted in cycles.
    bit              m_busy;
    int              m_age;
    int              m_id;
    int              m_ptr;
    logic [CNTW-1:0] m_cnt;
    logic [NREQ-1:0] c_rdy;
    int              c_gi;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_conv_count", conv_count, 0);
            chk("rst_out_binary", out_binary, 0);
            chk("rst_out_id", out_id, 0);
            m_busy = 1'b0;
            m_age  = 0;
            m_ptr  = 0;
            m_cnt  = '0;
            sb.delete();
        end else begin
            if (m_busy) m_age++;
            c_rdy = '0;
            c_gi  = -1;
            if (!m_busy) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (c_gi < 0 && req_valid[(m_ptr + k) % NREQ]) c_gi = (m_ptr + k) % NREQ;
                end
            end
            if (c_gi >= 0) c_rdy[c_gi] = 1'b1;
            chk("req_ready", req_ready, c_rdy);
            chk("busy", busy, m_busy);
            chk("out_valid", out_valid, m_busy && m_age >= 2);
            chk("conv_count", conv_count, m_cnt);
            if (c_gi >= 0) begin
                sb.push_back('{id: IDW'(c_gi), bin: g2b(req_gray[c_gi*WIDTH +: WIDTH])});
                m_busy = 1'b1;
                m_age  = 0;
                m_id   = c_gi;
            end else if (m_busy && m_age >= 2 && out_ready) begin
                m_busy = 1'b0;
                m_ptr  = (m_id + 1) % NREQ;
                m_cnt  = m_cnt + 1'b1;
            end
        end
    end

    // Monitor: compare whatever the DUT presents against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: got result id %0d, expected no result", out_id);
            end else begin
                chk("out_binary", out_binary, sb[0].bin);
                chk("out_id", out_id, sb[0].id);
                if (out_ready) begin
                    void'(sb.pop_front());
                    acc_ids.push_back(int'(out_id));
                end
            end
        end
    end

    // Stimulus: per-requester word queues presented in order.
    logic [WIDTH-1:0] src_q[NREQ][$];
    bit               drop_en;
    int               rdy_pct;

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (src_q[i].size() > 0);
            req_gray[i*WIDTH +: WIDTH] = (src_q[i].size() > 0) ? src_q[i][0] : WIDTH'($urandom);
        end
    endtask

    task automatic step();
        logic [NREQ-1:0] g;
        @(negedge clk);
        g = req_ready & req_valid;
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 99) < rdy_pct);
        for (int i = 0; i < NREQ; i++) begin
            if (g[i]) void'(src_q[i].pop_front());
            else if (drop_en && src_q[i].size() == 1 && $urandom_range(0, 15) == 0)
                void'(src_q[i].pop_front());
        end
        drive();
    endtask

    function automatic bit pending();
        bit p;
        p = busy || out_valid;
        for (int i = 0; i < NREQ; i++) if (src_q[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            step();
            n++;
        end
        chk({name, "_drain_in_budget"}, n < budget, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        drive();
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic chk_ids(input string name);
        chk({name, "_count"}, acc_ids.size(), exp_ids.size());
        for (int i = 0; i < exp_ids.size() && i < acc_ids.size(); i++)
            chk({name, "_order"}, acc_ids[i], exp_ids[i]);
        acc_ids.delete();
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        out_ready = 1'b1;
        req_valid = '0;
        req_gray  = '0;
        drop_en   = 1'b0;
        rdy_pct   = 100;
        do_reset();

        // Single request, out_ready high.
        src_q[0].push_back(5'b00100);
        drive();
        drain(20, "t1");
        chk("t1_count", conv_count, 1);
        exp_ids = '{0};
        chk_ids("t1_ids");

        // All four pending with requester 0 re-requesting: order 0,1,2,3,0.
        do_reset();
        src_q[0].push_back(5'b00001);
        src_q[1].push_back(5'b01001);
        src_q[2].push_back(5'b10010);
        src_q[3].push_back(5'b11101);
        src_q[0].push_back(5'b00110);
        drive();
        drain(60, "t2");
        chk("t2_count", conv_count, 5);
        exp_ids = '{0, 1, 2, 3, 0};
        chk_ids("t2_ids");

        // Consumer stall for 5 cycles while another requester waits.
        rdy_pct = 0;
        src_q[3].push_back(5'b10110);
        drive();
        n = 0;
        while (!out_valid && n < 10) begin
            step();
            n++;
        end
        chk("t3_out_valid_seen", out_valid, 1);
        src_q[0].push_back(5'b00011);
        drive();
        repeat (5) begin
            @(negedge clk);
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_binary", out_binary, 5'b11011);
            chk("t3_hold_ready", req_ready, 0);
            chk("t3_hold_busy", busy, 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        rdy_pct   = 100;
        @(posedge clk);
        #1;
        chk("t3_count", conv_count, 6);
        drain(20, "t3");
        exp_ids = '{3, 0};
        chk_ids("t3_ids");

        // Lone requesters, then a contended pair after the pointer has moved.
        src_q[3].push_back(5'b00101);
        drive();
        drain(20, "t4a");
        src_q[2].push_back(5'b01100);
        drive();
        drain(20, "t4b");
        src_q[1].push_back(5'b10001);
        src_q[2].push_back(5'b11111);
        drive();
        drain(30, "t4c");
        exp_ids = '{3, 2, 1, 2};
        chk_ids("t4_ids");

        // Reset during CONV and during OUT.
        src_q[0].push_back(5'b01010);
        drive();
        n = 0;
        while (!(busy && !out_valid) && n < 10) begin
            step();
            n++;
        end
        chk("t5_in_conv", busy && !out_valid, 1);
        rst = 1'b1;
        #1;
        chk("t5_conv_rst_valid", out_valid, 0);
        chk("t5_conv_rst_busy", busy, 0);
        chk("t5_conv_rst_count", conv_count, 0);
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        drive();
        step();
        rst     = 1'b0;
        rdy_pct = 0;
        out_ready = 1'b0;
        src_q[2].push_back(5'b11000);
        drive();
        n = 0;
        while (!out_valid && n < 10) begin
            step();
            n++;
        end
        chk("t5_in_out", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("t5_out_rst_valid", out_valid, 0);
        chk("t5_out_rst_busy", busy, 0);
        chk("t5_out_rst_binary", out_binary, 0);
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        drive();
        step();
        rst     = 1'b0;
        rdy_pct = 100;
        acc_ids.delete();
        src_q[3].push_back(5'b00111);
        src_q[0].push_back(5'b01111);
        drive();
        drain(30, "t5");
        exp_ids = '{0, 3};
        chk_ids("t5_ids");

        // Random traffic with legal drops and consumer back-pressure.
        drop_en = 1'b1;
        rdy_pct = 70;
        repeat (300) begin
            for (int i = 0; i < NREQ; i++)
                if ($urandom_range(0, 3) == 0 && src_q[i].size() < 3)
                    src_q[i].push_back(WIDTH'($urandom));
            step();
        end
        drop_en = 1'b0;
        drain(200, "rand");
        acc_ids.delete();

        // Every Gray word through every requester.
        do_reset();
        rdy_pct = 75;
        for (int i = 0; i < NREQ; i++)
            for (int g = 0; g < (1 << WIDTH); g++) src_q[i].push_back(WIDTH'(g));
        drive();
        drain(3000, "t6");
        chk("t6_count", conv_count, (NREQ << WIDTH) % (1 << CNTW));
        acc_ids.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
